// File: rtl/pwm_multi_ctrl.sv
// rtl/pwm_multi_ctrl.sv - multi-channel PWM with debounced up/down duty buttons
//
// Ports:
//   clk       sole clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   btn_up    raw increase button, active-high, asynchronous to clk
//   btn_dn    raw decrease button, active-high, asynchronous to clk
//   ch_sel    channel addressed by button presses (out-of-range values ignored)
//   pwm_out   registered PWM outputs, bit i = channel i
//   at_max    selected channel working duty == PERIOD (registered)
//   at_min    selected channel working duty == 0 (registered)
//   tick_1hz  square wave with a period of DIVISOR cycles
module pwm_multi_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int PERIOD    = 127,
    parameter int INIT_DUTY = 64,
    parameter int STEP      = 1,
    parameter int DEBOUNCE  = 511,
    parameter int REPEAT    = 0,
    parameter int DIVISOR   = 12500,
    localparam int SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_up,
    input  logic                btn_dn,
    input  logic [SW-1:0]       ch_sel,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                at_max,
    output logic                at_min,
    output logic                tick_1hz
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int RW = (REPEAT > 0) ? $clog2(REPEAT + 1) : 1;
    localparam int VW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    localparam logic [DW-1:0]    DB_MAX   = DW'(DEBOUNCE);
    localparam logic [DW-1:0]    DB_PRE   = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0]    REP_LAST = RW'((REPEAT > 0) ? REPEAT - 1 : 0);
    localparam logic [WIDTH-1:0] PER      = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] INIT     = WIDTH'(INIT_DUTY);
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   PER_W    = (WIDTH + 1)'(PERIOD);
    localparam logic [VW-1:0]    DIV_LAST = VW'(DIVISOR - 1);
    localparam logic [VW-1:0]    DIV_HALF = VW'(DIVISOR / 2);

    // Button index 0 = up, 1 = down throughout.
    logic [1:0]          btn_raw;
    logic [1:0]          sync_a;
    logic [1:0]          sync_b;
    logic [1:0][DW-1:0]  db_cnt;
    logic [1:0][RW-1:0]  rep_cnt;
    logic [1:0]          press;

    logic [CHANNELS-1:0][WIDTH-1:0] duty;
    logic [CHANNELS-1:0][WIDTH-1:0] shadow;
    logic [WIDTH-1:0]               per_cnt;
    logic [VW-1:0]                  div_cnt;

    logic             ch_ok;
    logic [WIDTH-1:0] cur_duty;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;

    assign btn_raw = {btn_dn, btn_up};

    // Two-flop synchroniser followed by a saturating hold counter per button.
    // The press pulse fires on the cycle the count becomes DEBOUNCE; while
    // still held, the repeat counter then fires every REPEAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a  <= '0;
            sync_b  <= '0;
            db_cnt  <= '0;
            rep_cnt <= '0;
            press   <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            for (int b = 0; b < 2; b++) begin
                if (!sync_b[b]) begin
                    db_cnt[b]  <= '0;
                    rep_cnt[b] <= '0;
                    press[b]   <= 1'b0;
                end else if (db_cnt[b] != DB_MAX) begin
                    db_cnt[b]  <= db_cnt[b] + 1'b1;
                    rep_cnt[b] <= '0;
                    press[b]   <= (db_cnt[b] == DB_PRE);
                end else if ((REPEAT > 0) && (rep_cnt[b] == REP_LAST)) begin
                    rep_cnt[b] <= '0;
                    press[b]   <= 1'b1;
                end else begin
                    rep_cnt[b] <= rep_cnt[b] + 1'b1;
                    press[b]   <= 1'b0;
                end
            end
        end
    end

    assign ch_ok    = (32'(ch_sel) < CHANNELS);
    assign cur_duty = duty[ch_sel];

    // Saturating step arithmetic done one bit wider so it cannot wrap.
    assign sum_w  = {1'b0, cur_duty} + STEP_W;
    assign up_val = (sum_w > PER_W) ? PER : sum_w[WIDTH-1:0];
    assign dn_val = ({1'b0, cur_duty} < STEP_W) ? '0 : (cur_duty - STEP_W[WIDTH-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty   <= {CHANNELS{INIT}};
            shadow <= {CHANNELS{INIT}};
            at_max <= 1'b0;
            at_min <= 1'b0;
        end else begin
            // Simultaneous up and down presses cancel out.
            if (ch_ok && (press == 2'b01)) begin
                duty[ch_sel] <= up_val;
            end else if (ch_ok && (press == 2'b10)) begin
                duty[ch_sel] <= dn_val;
            end
            // Shadow copy on the last count so every period starts clean.
            if (per_cnt == PER) begin
                shadow <= duty;
            end
            at_max <= ch_ok && (cur_duty == PER);
            at_min <= ch_ok && (cur_duty == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            pwm_out <= '0;
        end else begin
            per_cnt <= (per_cnt == PER) ? '0 : per_cnt + 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= (per_cnt < shadow[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            tick_1hz <= 1'b0;
        end else begin
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            tick_1hz <= (div_cnt < DIV_HALF);
        end
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// tb/tb_pwm_multi_ctrl.sv - directed self-checking bench for pwm_multi_ctrl
`timescale 1ns/1ps
module tb_pwm_multi_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       up_a, dn_a;
    logic [1:0] sel_a;
    logic [3:0] pwm_a;
    logic       max_a, min_a, tick_a;

    logic       up_b, dn_b;
    logic [1:0] sel_b;
    logic [2:0] pwm_b;
    logic       max_b, min_b, tick_b;

    pwm_multi_ctrl dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (up_a),
        .btn_dn   (dn_a),
        .ch_sel   (sel_a),
        .pwm_out  (pwm_a),
        .at_max   (max_a),
        .at_min   (min_a),
        .tick_1hz (tick_a)
    );

    pwm_multi_ctrl #(.CHANNELS(3), .REPEAT(100)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (up_b),
        .btn_dn   (dn_b),
        .ch_sel   (sel_b),
        .pwm_out  (pwm_b),
        .at_max   (max_b),
        .at_min   (min_b),
        .tick_1hz (tick_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic measure(input bit which_b, input int ch, output int hi);
        hi = 0;
        for (int i = 0; i < 128; i++) begin
            cycles(1);
            if (which_b ? pwm_b[ch] : pwm_a[ch]) hi++;
        end
    endtask

    task automatic press_a(input logic u, input logic d, input int hold);
        up_a = u;
        dn_a = d;
        cycles(hold);
        up_a = 1'b0;
        dn_a = 1'b0;
        cycles(6);
    endtask

    task automatic press_b(input logic u, input logic d, input int hold);
        up_b = u;
        dn_b = d;
        cycles(hold);
        up_b = 1'b0;
        dn_b = 1'b0;
        cycles(6);
    endtask

    initial begin
        int h;
        int bad;
        int k;
        int hi_cnt [4];
        int seen_max;
        int drops;

        rst_n = 1'b0;
        up_a = 1'b0; dn_a = 1'b0; sel_a = 2'd0;
        up_b = 1'b0; dn_b = 1'b0; sel_b = 2'd0;
        cycles(3);
        check("rst_pwm", pwm_a, 0);
        check("rst_at_max", max_a, 0);
        check("rst_at_min", min_a, 0);
        check("rst_tick", tick_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default duty: all channels 64/128, in phase.
        bad = 0;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        for (int i = 0; i < 128; i++) begin
            cycles(1);
            if (pwm_a != 4'h0 && pwm_a != 4'hF) bad++;
            for (int c = 0; c < 4; c++) if (pwm_a[c]) hi_cnt[c]++;
        end
        for (int c = 0; c < 4; c++) check($sformatf("init_duty_ch%0d", c), hi_cnt[c], 64);
        check("init_in_phase", bad, 0);
        check("init_at_max", max_a, 0);
        check("init_at_min", min_a, 0);

        // Short press rejected, long press accepted once.
        sel_a = 2'd1;
        press_a(1'b1, 1'b0, 400);
        cycles(300);
        measure(1'b0, 1, h);
        check("short_press_ch1", h, 64);
        press_a(1'b1, 1'b0, 600);
        cycles(300);
        measure(1'b0, 1, h);
        check("long_press_ch1", h, 65);
        measure(1'b0, 0, h);
        check("long_press_ch0", h, 64);

        // Drive channel 2 down to zero and beyond.
        sel_a = 2'd2;
        for (int p = 0; p < 64; p++) press_a(1'b0, 1'b1, 520);
        cycles(3);
        check("ch2_at_min", min_a, 1);
        check("ch2_at_max", max_a, 0);
        cycles(300);
        measure(1'b0, 2, h);
        check("ch2_zero_duty", h, 0);
        press_a(1'b0, 1'b1, 520);
        cycles(300);
        check("ch2_65th_at_min", min_a, 1);
        measure(1'b0, 2, h);
        check("ch2_65th_zero", h, 0);

        // Simultaneous up+down presses cancel.
        sel_a = 2'd1;
        press_a(1'b1, 1'b1, 600);
        cycles(300);
        measure(1'b0, 1, h);
        check("both_press_ch1", h, 65);

        // Asynchronous reset while an output is high.
        k = 0;
        while (!pwm_a[0] && k < 300) begin
            cycles(1);
            k++;
        end
        check("wait_pwm_high", pwm_a[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", pwm_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // tick_1hz: 6250 high then 6250 low from reset release.
        cycles(1);
        h = 0;
        while (tick_a && h < 20000) begin
            h++;
            cycles(1);
        end
        check("tick_high_len", h, 6250);
        h = 0;
        while (!tick_a && h < 20000) begin
            h++;
            cycles(1);
        end
        check("tick_low_len", h, 6250);
        measure(1'b0, 1, h);
        check("post_rst_ch1", h, 64);
        measure(1'b0, 2, h);
        check("post_rst_ch2", h, 64);
        sel_a = 2'd2;
        cycles(3);
        check("post_rst_at_min", min_a, 0);

        // Auto-repeat on the second instance saturates at PERIOD.
        sel_b = 2'd0;
        up_b = 1'b1;
        seen_max = 0;
        drops = 0;
        for (int i = 0; i < 10000; i++) begin
            cycles(1);
            if (max_b) seen_max = 1;
            else if (seen_max != 0) drops++;
        end
        up_b = 1'b0;
        cycles(6);
        check("repeat_reached_max", seen_max, 1);
        check("repeat_no_wrap", drops, 0);
        cycles(300);
        measure(1'b1, 0, h);
        check("repeat_duty_127", h, 127);
        check("repeat_at_max", max_b, 1);

        // Out-of-range channel select is ignored.
        sel_b = 2'd3;
        press_b(1'b0, 1'b1, 600);
        check("oor_at_max", max_b, 0);
        check("oor_at_min", min_b, 0);
        sel_b = 2'd0;
        cycles(3);
        check("oor_ch0_unchanged", max_b, 1);
        press_b(1'b0, 1'b1, 600);
        cycles(300);
        measure(1'b1, 0, h);
        check("single_dn_ch0", h, 126);
        check("single_dn_at_max", max_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
